dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters. Port 0 is the CPU MEM-stage load/store path; port 1 is the loader/debug master that fills or inspects data memory.
- Each transfer uses a req/ack handshake. Both ports are served with round-robin priority.
- Sits between the requesters and the data memory, which has a 1-cycle registered read latency. The CPU derives its pipeline stall from m0_req && !m0_ack.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between two requesters. Port 0 is the
// CPU MEM-stage load/store path, port 1 is the loader/debug master. Each
// transfer is a req/ack handshake. The two ports are granted round-robin.
// Every transfer takes three cycles: IDLE (arbitrate and latch the
// request), ACCESS (memory strobe) and RESP (ack pulse plus read data).
//
// Ports
//   clk, reset           rising-edge clock, synchronous active-high reset
//   mX_req               port X request, held high until mX_ack
//   mX_we                port X direction: 1 = write, 0 = read
//   mX_addr, mX_wdata    port X address and write data
//   mX_ack               port X one-cycle completion pulse
//   mX_rdata             port X read data, valid from the ack cycle and held
//                        until the next port-X read completes
//   mem_addr, mem_wdata  memory address and write data
//   mem_read, mem_write  one-cycle memory strobes, issued in ACCESS
//   mem_rdata            memory read data, valid the cycle after mem_read
//   busy                 high while a transfer is in flight
//   grant_id             port that owns the current transfer, 0 when idle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              we_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Winner of the current IDLE-cycle arbitration. On a tie the port that
    // did not win last time gets the memory.
    logic pick;
    logic pick_we;

    // NOTE: every signal written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) begin
            pick = ~last_grant;
        end else if (m1_req) begin
            pick = 1'b1;
        end
        pick_we = pick ? m1_we : m0_we;
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses.
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state      <= ACCESS;
                        busy       <= 1'b1;
                        grant_id   <= pick;
                        last_grant <= pick;
                        // The request is captured here; later changes on the
                        // requester's inputs cannot disturb this transfer.
                        we_q       <= pick_we;
                        mem_addr   <= pick ? m1_addr  : m0_addr;
                        mem_wdata  <= pick ? m1_wdata : m0_wdata;
                        mem_read   <= ~pick_we;
                        mem_write  <= pick_we;
                    end
                end

                ACCESS: begin
                    state  <= RESP;
                    m0_ack <= ~grant_id;
                    m1_ack <= grant_id;
                end

                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    grant_id <= 1'b0;
                    if (!we_q) begin
                        if (grant_id) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end
                end

                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    grant_id <= 1'b0;
                end
            endcase
        end
    end

    // During the ack cycle the memory's read data is forwarded straight
    // through, so the requester sees it in the same cycle as its ack; the
    // register keeps it afterwards.
    assign m0_rdata = (state == RESP && !grant_id && !we_q) ? mem_rdata : rdata0_q;
    assign m1_rdata = (state == RESP &&  grant_id && !we_q) ? mem_rdata : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Self-checking bench for dmem_arbiter. The stimulus process pushes every
// issued request onto a per-port expectation queue. A separate monitor,
// running on the falling edge, models the arbiter at the transfer level:
// round-robin grant decisions, a reference memory image and the held read
// data of each port. It compares each visible DUT output against that model.
// A simple memory responder answers reads one cycle after mem_read.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;

    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read, mem_write;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, grant_id;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    txn_t exp_q0[$];
    txn_t exp_q1[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // ---------------------------------------------------------------- memory
    logic [DW-1:0] env_mem [64];
    initial begin : memory_model
        logic          rd;
        logic [5:0]    ra;
        for (int i = 0; i < 64; i++) env_mem[i] = '0;
        forever begin
            @(negedge clk);
            rd = mem_read;
            ra = mem_addr[7:2];
            if (mem_write) env_mem[mem_addr[7:2]] = mem_wdata;
            @(posedge clk);
            #1;
            // Garbage outside the read-response cycle exposes a wrong capture cycle.
            mem_rdata = rd ? env_mem[ra] : $urandom;
        end
    end

    // --------------------------------------------------------------- monitor
    logic [DW-1:0] ref_mem [64];
    bit            rst_pend  = 1'b1;
    bit            grant_due = 1'b0;
    bit            ack_due   = 1'b0;
    bit            last_win  = 1'b1;
    bit            pend0, pend1, winner, cur_port, in_access, in_resp;
    txn_t          cur;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] hold0 = '0, hold1 = '0;

    initial begin : monitor
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_pend) begin
                check("reset busy", busy, 0);
                check("reset acks", {m1_ack, m0_ack}, 0);
                check("reset strobes", {mem_read, mem_write}, 0);
                check("reset grant_id", grant_id, 0);
                check("reset m0_rdata", m0_rdata, 0);
                check("reset m1_rdata", m1_rdata, 0);
                check("reset mem_addr", mem_addr, 0);
                check("reset mem_wdata", mem_wdata, 0);
                exp_q0.delete();
                exp_q1.delete();
                grant_due = 1'b0;
                ack_due   = 1'b0;
                last_win  = 1'b1;
                hold0     = '0;
                hold1     = '0;
            end else begin
                in_access = grant_due;
                in_resp   = ack_due;

                if (in_resp) begin
                    check("m0_ack", m0_ack, cur_port == 1'b0);
                    check("m1_ack", m1_ack, cur_port == 1'b1);
                    check("grant_id resp", grant_id, cur_port);
                    if (!cur.we) begin
                        if (cur_port) hold1 = exp_rd;
                        else          hold0 = exp_rd;
                    end
                end else begin
                    check("no ack", {m1_ack, m0_ack}, 0);
                end

                if (in_access) begin
                    winner   = (pend0 && pend1) ? !last_win : pend1;
                    last_win = winner;
                    cur_port = winner;
                    check("grant_id", grant_id, winner);
                    if ((winner && exp_q1.size() == 0) || (!winner && exp_q0.size() == 0)) begin
                        check("grant without request", 1, 0);
                        cur = '0;
                    end else begin
                        cur = winner ? exp_q1.pop_front() : exp_q0.pop_front();
                    end
                    check("mem_read", mem_read, !cur.we);
                    check("mem_write", mem_write, cur.we);
                    check("mem_addr", mem_addr, cur.addr);
                    if (cur.we) begin
                        check("mem_wdata", mem_wdata, cur.wdata);
                        ref_mem[cur.addr[7:2]] = cur.wdata;
                    end else begin
                        exp_rd = ref_mem[cur.addr[7:2]];
                    end
                end else begin
                    check("no strobe", {mem_read, mem_write}, 0);
                end

                check("busy", busy, in_access || in_resp);
                if (!in_access && !in_resp) check("grant_id idle", grant_id, 0);
                check("m0_rdata", m0_rdata, hold0);
                check("m1_rdata", m1_rdata, hold1);

                ack_due   = in_access;
                grant_due = 1'b0;
                if (!in_access && !in_resp) begin
                    pend0     = m0_req;
                    pend1     = m1_req;
                    grant_due = pend0 || pend1;
                end
            end
            rst_pend = reset;
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic start(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d;
        if (p == 0) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
            exp_q0.push_back(t);
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
            exp_q1.push_back(t);
        end
    endtask

    task automatic start_rand(input int p);
        start(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2, $urandom);
    endtask

    task automatic drop(input int p);
        if (p == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
    endtask

    // Changes a port's inputs while its transfer is already under way.
    task automatic scramble(input int p);
        if (p == 0) begin m0_addr = $urandom; m0_wdata = $urandom; m0_we = ~m0_we; end
        else        begin m1_addr = $urandom; m1_wdata = $urandom; m1_we = ~m1_we; end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_any_ack(output int who, output int at);
        bit got = 1'b0;
        who = -1;
        at  = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                got = 1'b1;
                who = m1_ack ? 1 : 0;
                at  = cyc;
            end
        end
        check("ack timeout", got, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int p, output int at);
        int who;
        wait_any_ack(who, at);
        check("ack port", who, p);
    endtask

    task automatic wait_strobe();
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            #1;
            if (mem_read || mem_write) got = 1'b1;
        end
        check("strobe timeout", got, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int  t0, t1, who, prev;
    int  left[2];
    bit  active[2];
    bit  seen[2];
    bit  acc_p;

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // m0 write, then read back
        start(0, 1'b1, 32'h10, 32'hDEADBEEF);
        wait_ack(0, t0);
        drop(0);
        start(0, 1'b0, 32'h10, 32'h0);
        wait_ack(0, t0);
        drop(0);
        repeat (2) @(posedge clk);
        #1;
        check("m0_rdata hold after req drop", m0_rdata, 32'hDEADBEEF);

        // tie right after reset: port 0 first, port 1 three cycles later
        do_reset();
        start(0, 1'b1, 32'h30, 32'hA5A50001);
        start(1, 1'b0, 32'h30, 32'h0);
        wait_ack(0, t0);
        drop(0);
        wait_ack(1, t1);
        drop(1);
        check("m1 ack spacing after m0", t1 - t0, 3);

        // both ports requesting continuously for six transfers
        start_rand(0);
        start_rand(1);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            wait_any_ack(who, t0);
            check("round-robin order", who, k % 2);
            if (k > 0) check("round-robin spacing", t0 - prev, 3);
            prev = t0;
            if (k >= 4) drop(who);
            else        start_rand(who);
        end

        // m1 read with address changed during ACCESS
        start(1, 1'b0, 32'h10, 32'h0);
        wait_strobe();
        m1_addr = 32'h44;
        @(negedge clk);
        check("mem_addr stable during ACCESS", mem_addr, 32'h10);
        wait_ack(1, t1);
        drop(1);

        // reset during the ACCESS cycle of an m0 write
        start(0, 1'b1, 32'h20, 32'h12345678);
        wait_strobe();
        reset = 1'b1;
        drop(0);
        @(posedge clk);
        #1 reset = 1'b0;
        check("busy after reset in ACCESS", busy, 0);
        @(posedge clk);
        #1;
        start(0, 1'b0, 32'h20, 32'h0);
        start(1, 1'b0, 32'h30, 32'h0);
        wait_any_ack(who, t0);
        check("tie winner after reset", who, 0);
        drop(0);
        wait_ack(1, t1);
        drop(1);

        // randomized traffic
        left[0] = 40; left[1] = 40;
        active[0] = 1'b0; active[1] = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (left[0] == 0 && left[1] == 0 && !active[0] && !active[1]) break;
            @(negedge clk);
            seen[0] = m0_ack;
            seen[1] = m1_ack;
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                acc_p = (mem_read || mem_write) && (grant_id == 1'(p));
                if (active[p]) begin
                    if (seen[p]) begin
                        active[p] = 1'b0;
                        left[p]--;
                        if (left[p] > 0 && $urandom_range(0, 1) == 1) begin
                            start_rand(p);
                            active[p] = 1'b1;
                        end else begin
                            drop(p);
                        end
                    end else if (acc_p) begin
                        scramble(p);
                        if ($urandom_range(0, 3) == 0) drop(p);
                    end
                end else if (left[p] > 0 && $urandom_range(0, 2) == 0) begin
                    start_rand(p);
                    active[p] = 1'b1;
                end
            end
        end
        check("random traffic drained", left[0] + left[1] + int'(active[0]) + int'(active[1]), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
